// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file geometry and scoreboard types.
// FEATURE_RV32E selects the 16-entry register file.
package reg_scoreboard_pkg;

`ifdef FEATURE_RV32E
  localparam int unsigned NumRegs = 16;
`else
  localparam int unsigned NumRegs = 32;
`endif

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CntW     = 2;

  typedef logic [RegAddrW-1:0] reg_idx_t;
  typedef logic [CntW-1:0]     scb_cnt_t;

  // Largest number of outstanding writes a counter of width w can hold.
  function automatic int unsigned cnt_max(int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Pending-write counter for one architectural register.
// Applies issue/write-back/kill in a single step and clamps at zero on underflow.
module reg_scoreboard_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             wbdec_i,
  input  logic             killdec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   up, dn;

  always_comb begin
    up          = {1'b0, count_q} + (CNT_W + 1)'(inc_i);
    dn          = (CNT_W + 1)'(wbdec_i) + (CNT_W + 1)'(killdec_i);
    underflow_o = (up < dn);
    // The issue guard keeps the net result within range, so modular math is exact.
    count_d     = count_q + CNT_W'(inc_i) - CNT_W'(wbdec_i) - CNT_W'(killdec_i);
    if (underflow_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (count_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters and the issue stall.
// x0 is never tracked; indices wrap to the register-file width.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS   = NumRegs,
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned CNT_W      = CntW
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_writes_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic                  issue_uses_rs1_i,
  input  logic                  issue_uses_rs2_i,
  output logic                  issue_ready_o,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  kill_valid_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam int unsigned IdxW   = $clog2(NUM_REGS);
  localparam int unsigned CmpW   = CNT_W + 2;
  localparam int unsigned MaxCnt = cnt_max(CNT_W);

  logic [IdxW-1:0] rd_idx, rs1_idx, rs2_idx, wb_idx, kill_idx;

  assign rd_idx   = issue_rd_i[IdxW-1:0];
  assign rs1_idx  = issue_rs1_i[IdxW-1:0];
  assign rs2_idx  = issue_rs2_i[IdxW-1:0];
  assign wb_idx   = wb_rd_i[IdxW-1:0];
  assign kill_idx = kill_rd_i[IdxW-1:0];

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] uflow;
  logic [CmpW-1:0]     dec_rs1, dec_rs2, dec_rd;
  logic                src1_hz, src2_hz, dst_full, issue_fire;
  logic                err_q, err_d;

  assign cnt[0]   = '0;
  assign busy[0]  = 1'b0;
  assign uflow[0] = 1'b0;

  // Same-cycle write-back or kill releases a source (data is forwarded or consumer squashed).
  always_comb begin
    dec_rs1  = CmpW'(wb_valid_i && (wb_idx == rs1_idx))
             + CmpW'(kill_valid_i && (kill_idx == rs1_idx));
    dec_rs2  = CmpW'(wb_valid_i && (wb_idx == rs2_idx))
             + CmpW'(kill_valid_i && (kill_idx == rs2_idx));
    dec_rd   = CmpW'(wb_valid_i && (wb_idx == rd_idx))
             + CmpW'(kill_valid_i && (kill_idx == rd_idx));
    src1_hz  = issue_uses_rs1_i && (rs1_idx != '0) && (CmpW'(cnt[rs1_idx]) > dec_rs1);
    src2_hz  = issue_uses_rs2_i && (rs2_idx != '0) && (CmpW'(cnt[rs2_idx]) > dec_rs2);
    dst_full = issue_writes_i && (rd_idx != '0)
             && (CmpW'(cnt[rd_idx]) == (CmpW'(MaxCnt) + dec_rd));
    issue_ready_o = !(src1_hz || src2_hz || dst_full);
    issue_fire    = issue_valid_i && issue_ready_o && issue_writes_i && (rd_idx != '0);
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    reg_scoreboard_counter #(
      .CNT_W(CNT_W)
    ) u_counter (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (issue_fire && (rd_idx == IdxW'(r))),
      .wbdec_i    (wb_valid_i && (wb_idx == IdxW'(r))),
      .killdec_i  (kill_valid_i && (kill_idx == IdxW'(r))),
      .count_o    (cnt[r]),
      .busy_o     (busy[r]),
      .underflow_o(uflow[r])
    );
  end

  always_comb begin
    err_d = err_q || (|uflow);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign busy_o = busy;
  assign idle_o = ~|busy;
  assign err_o  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed check of reg_scoreboard against a count-per-register model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv, iw, u1, u2, wbv, kv;
  logic [4:0]  rd, rs1, rs2, wbrd, krd;
  logic        ready;
  logic [31:0] busy;
  logic        idle, err;

  int total = 0;
  int bad   = 0;
  int cnt_m [32];
  bit err_m;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .issue_valid_i   (iv),
    .issue_writes_i  (iw),
    .issue_rd_i      (rd),
    .issue_rs1_i     (rs1),
    .issue_rs2_i     (rs2),
    .issue_uses_rs1_i(u1),
    .issue_uses_rs2_i(u2),
    .issue_ready_o   (ready),
    .wb_valid_i      (wbv),
    .wb_rd_i         (wbrd),
    .kill_valid_i    (kv),
    .kill_rd_i       (krd),
    .busy_o          (busy),
    .idle_o          (idle),
    .err_o           (err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec_of(int s);
    return int'(wbv && (wbrd == s)) + int'(kv && (krd == s));
  endfunction

  function automatic bit exp_ready();
    if (u1 && rs1 != 0 && cnt_m[rs1] > dec_of(int'(rs1))) return 1'b0;
    if (u2 && rs2 != 0 && cnt_m[rs2] > dec_of(int'(rs2))) return 1'b0;
    if (iw && rd != 0 && cnt_m[rd] - dec_of(int'(rd)) == 3) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (cnt_m[r] != 0);
    return b;
  endfunction

  task automatic drive(bit v, bit w, int d, int a, int b, bit ua, bit ub,
                       bit wv, int wr, bit kvv, int kr);
    iv = v; iw = w; rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b); u1 = ua; u2 = ub;
    wbv = wv; wbrd = 5'(wr); kv = kvv; krd = 5'(kr);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare against the model, then advance one clock and update the model.
  task automatic cycle();
    bit rdy;
    int n;
    rdy = exp_ready();
    chk("ready", 32'(ready), 32'(rdy));
    chk("busy", busy, exp_busy());
    chk("idle", 32'(idle), 32'(exp_busy() == 0));
    chk("err", 32'(err), 32'(err_m));
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      err_m = 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        n = cnt_m[r] + int'(iv && rdy && iw && rd == r) - int'(wbv && wbrd == r)
          - int'(kv && krd == r);
        if (n < 0) begin
          n = 0;
          err_m = 1'b1;
        end
        cnt_m[r] = n;
      end
    end
    @(negedge clk);
  endtask

  function automatic int pick_reg();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 4));
    return int'($urandom_range(0, 31));
  endfunction

  function automatic int pick_busy();
    int s;
    s = int'($urandom_range(0, 31));
    for (int i = 0; i < 32; i++) begin
      if (cnt_m[(s + i) % 32] != 0) return (s + i) % 32;
    end
    return pick_reg();
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    err_m = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    idle_in();
    cycle();
    reset = 1'b0;

    // Reset state.
    idle_in();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    cycle();

    // RAW on x5, released by same-cycle write-back.
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0);
    chk("raw_stall", 32'(ready), 32'd0);
    chk("raw_busy5", 32'(busy[5]), 32'd1);
    cycle();
    drive(1, 0, 0, 5, 0, 1, 0, 1, 5, 0, 0);
    chk("raw_wb_release", 32'(ready), 32'd1);
    cycle();
    idle_in();
    chk("raw_busy5_clr", 32'(busy[5]), 32'd0);
    cycle();

    // Issue and write-back to x7 in one cycle.
    drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
    cycle();
    idle_in();
    chk("same_cycle_busy7", 32'(busy[7]), 32'd1);
    chk("same_cycle_cnt7", 32'(cnt_m[7]), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    cycle();

    // WAW saturation on x3.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
    end
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dst_full", 32'(ready), 32'd0);
    cycle();
    drive(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0);
    chk("dst_full_wb", 32'(ready), 32'd1);
    cycle();
    idle_in();
    chk("cnt3_model", 32'(cnt_m[3]), 32'd3);
    chk("busy3", 32'(busy[3]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
      cycle();
    end

    // x0 is never tracked.
    drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("x0_ready", 32'(ready), 32'd1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_busy", busy, 32'd0);
    chk("x0_idle", 32'(idle), 32'd1);
    cycle();
    idle_in();
    chk("x0_err", 32'(err), 32'd0);
    cycle();

    // Underflow on x9, sticky until reset.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    chk("uf_err", 32'(err), 32'd1);
    chk("uf_busy9", 32'(busy[9]), 32'd0);
    cycle();
    idle_in();
    chk("uf_err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle_in();
    chk("uf_err_cleared", 32'(err), 32'd0);
    chk("uf_idle", 32'(idle), 32'd1);
    cycle();

    // Kill releases x12 for a same-cycle consumer.
    drive(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 12, 0, 1, 0, 0, 1, 12);
    chk("kill_release", 32'(ready), 32'd1);
    cycle();
    idle_in();
    chk("kill_busy12", 32'(busy[12]), 32'd0);
    cycle();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0), pick_reg(),
            pick_reg(), pick_reg(), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0) ? pick_reg() : pick_busy(),
            bit'($urandom_range(0, 5) == 0),
            ($urandom_range(0, 19) == 0) ? pick_reg() : pick_busy());
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Tracks in-flight writes to the architectural register file so the issue stage only dispatches an instruction once all its source registers are available. Holds a small pending-write counter per register: incremented when a writing instruction issues, decremented at writeback or when the instruction is killed. Sits between decode/issue and the register file write-back port, and produces the issue stall.

Parameters:
NUM_REGS, 32, number of architectural registers (16 for RV32E builds); legal values 16 or 32.
REG_ADDR_W, 5, register index width; 5 always, since ports carry full 5-bit indices.
CNT_W, 2, per-register pending counter width; at most 2**CNT_W-1 outstanding writes per register.

Ports:
clk_i  in  1  core clock
reset_i  in  1  synchronous, active-high reset
issue_valid_i  in  1  issue stage offers an instruction this cycle
issue_writes_i  in  1  offered instruction writes rd
issue_rd_i  in  5  destination register
issue_rs1_i  in  5  source 1
issue_rs2_i  in  5  source 2
issue_uses_rs1_i  in  1  source 1 is read
issue_uses_rs2_i  in  1  source 2 is read
issue_ready_o  out  1  instruction may issue; issue happens when valid & ready
wb_valid_i  in  1  write-back to register file this cycle (same strobe as the register file write enable)
wb_rd_i  in  5  write-back destination
kill_valid_i  in  1  one issued-but-squashed writing instruction is retired without write-back
kill_rd_i  in  5  its destination
busy_o  out  NUM_REGS  bit r set when count[r] != 0 (registered view)
idle_o  out  1  all counters zero
err_o  out  1  sticky: write-back/kill to a register with count 0

Behaviour:
- State: count[r] of CNT_W bits for r in 1..NUM_REGS-1. Register x0 is never tracked: count[0] is always 0 and busy_o[0] is always 0. Indices >= NUM_REGS are truncated to the low address bits, identical to register file indexing.
- Reset (reset_i high at a clock edge): all counts 0, err_o 0. Outputs after reset: busy_o all 0, idle_o 1, issue_ready_o = 1 (combinational, if no hazard).
- src_hazard(s) for an active source s != 0: count[s] > dec[s], where dec[s] = number of wb/kill events targeting s this cycle.
  - Same-cycle write-back releases the source, because the register file forwards the write-back data combinationally.
  - A kill also releases it; the consumer is squashed by the pipeline anyway.
- dst_full: issue_writes_i & issue_rd_i != 0 & count[rd] - dec[rd] == max. This is a WAW overflow guard.
- issue_ready_o = !(src_hazard(rs1) | src_hazard(rs2) | dst_full). Purely combinational; it does not depend on issue_valid_i.
- Per-cycle update for each register r: count[r] <= count[r] + inc - wbdec - killdec, where
  - inc = valid & ready & writes & rd == r & r != 0;
  - wbdec and killdec are each 0 or 1.
  - All three events may hit the same register in the same cycle; the net is applied in one step.
- Underflow: if a wb or kill targets r != 0 with count[r] == 0 and no same-cycle inc to r, then count[r] stays 0 and err_o is set (sticky until reset).
- wb and kill to x0 are ignored and never raise err_o.
- busy_o and idle_o are derived from registered counts only. An update becomes visible the cycle after the event.
- Reset mid-operation clears all state regardless of in-flight instructions. The pipeline flush accompanying reset ensures no stale write-back follows.
- Issue-to-stall latency: an instruction issuing at cycle t makes its dependants stall from cycle t+1.

Decomposition:
- core_defines package: reg_idx_t (5-bit), the NUM_REGS/REG_ADDR_W constants shared with the register file under FEATURE_RV32E, and scb_cnt_t.
- Sub-module: reg_scoreboard_counter, one instance per register. Inputs inc/wbdec/killdec, outputs count, busy, underflow. It is generated NUM_REGS-1 times; the top level holds only decode, hazard logic and the err/idle reduction.

Test Plan:
- After reset: issue rd=5 writing, then rs1=5 the next cycle -> issue_ready_o=0, busy_o[5]=1. Assert wb rd=5 -> ready=1 that same cycle; busy_o[5]=0 one cycle later.
- Same-cycle issue rd=7 plus wb rd=7 with count[7]=1 -> count stays 1, busy_o[7] remains 1.
- Three issues to rd=3 with no wb -> count=3; a fourth writing rd=3 -> issue_ready_o=0 (dst_full). One wb to 3 -> the fourth issues in that cycle; count stays 3.
- x0: issue rd=0, rs1=0, rs2=0 -> ready=1, busy_o=0, idle_o=1. wb rd=0 -> err_o stays 0.
- Underflow: wb rd=9 with count 0 -> err_o=1 and count[9]=0. A further kill rd=9 -> err_o stays 1. reset_i high one cycle -> err_o=0, idle_o=1.
- Issue rd=12 then kill rd=12 -> busy_o[12] clears the next cycle; a dependent rs2=12 is ready in the kill cycle.
